// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word requests to a variable-latency
// instruction memory, buffers responses in order and squashes in-flight work on redirect.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Redirect_i,
    input  logic [31:0] RedirectPC_i,
    output logic        ImemReqValid_o,
    input  logic        ImemReqReady_i,
    output logic [31:0] ImemAddr_o,
    input  logic        ImemRespValid_i,
    input  logic [31:0] ImemRespData_i,
    output logic        InstrValid_o,
    input  logic        InstrReady_i,
    output logic [31:0] Instr_o,
    output logic [31:0] InstrPC_o,
    output logic [31:0] InstrPCPlus4_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fpc_q, fpc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [IW-1:0] qrd_q, qrd_d, qwr_q, qwr_d;
    logic [IW-1:0] trd_q, trd_d, twr_q, twr_d;
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_instr_d [DEPTH];
    logic [31:0]   q_pc_q    [DEPTH];
    logic [31:0]   q_pc_d    [DEPTH];
    logic [31:0]   tag_pc_q  [DEPTH];
    logic [31:0]   tag_pc_d  [DEPTH];

    logic [CW:0]   inflight;
    logic          req_valid, accept, resp, keep, pop, head_valid;
    logic [31:0]   redirect_target;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IW'(1);
    endfunction

    assign inflight        = {1'b0, count_q} + {1'b0, out_q};
    assign req_valid       = !rst_i && (state_q == RUN) && (32'(inflight) < DEPTH);
    assign accept          = req_valid && ImemReqReady_i;
    assign resp            = ImemRespValid_i;
    assign keep            = resp && (drop_q == '0);
    assign head_valid      = (count_q != '0);
    assign pop             = head_valid && InstrReady_i;
    assign redirect_target = RedirectPC_i & ~32'd3;

    always_comb begin
        state_d   = state_q;
        fpc_d     = fpc_q;
        drop_d    = drop_q;
        count_d   = count_q;
        qrd_d     = qrd_q;
        qwr_d     = qwr_q;
        trd_d     = trd_q;
        twr_d     = twr_q;
        q_instr_d = q_instr_q;
        q_pc_d    = q_pc_q;
        tag_pc_d  = tag_pc_q;

        // The tag FIFO tracks every outstanding request, including ones later squashed,
        // so discarded responses still retire their own tag.
        if (accept) begin
            tag_pc_d[twr_q] = fpc_q;
            twr_d           = ptr_inc(twr_q);
            fpc_d           = fpc_q + 32'd4;
        end
        if (resp) begin
            trd_d = ptr_inc(trd_q);
        end
        out_d = out_q + CW'(accept) - CW'(resp);

        if (Redirect_i) begin
            fpc_d   = redirect_target;
            count_d = '0;
            qrd_d   = '0;
            qwr_d   = '0;
            if (state_q == RUN) begin
                drop_d  = out_d;
                state_d = (out_d != '0) ? DRAIN : RUN;
            end else begin
                drop_d  = drop_q - CW'(resp);
                state_d = (drop_d == '0) ? RUN : DRAIN;
            end
        end else begin
            if (keep) begin
                q_instr_d[qwr_q] = ImemRespData_i;
                q_pc_d[qwr_q]    = tag_pc_q[trd_q];
                qwr_d            = ptr_inc(qwr_q);
            end
            if (pop) begin
                qrd_d = ptr_inc(qrd_q);
            end
            count_d = count_q + CW'(keep) - CW'(pop);
            if (resp && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if ((state_q == DRAIN) && (drop_d == '0)) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            fpc_q   <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
            count_q <= '0;
            qrd_q   <= '0;
            qwr_q   <= '0;
            trd_q   <= '0;
            twr_q   <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            qrd_q   <= qrd_d;
            qwr_q   <= qwr_d;
            trd_q   <= trd_d;
            twr_q   <= twr_d;
        end
    end

    // Storage needs no reset: entries are only observed behind a valid count.
    always_ff @(posedge clk_i) begin
        q_instr_q <= q_instr_d;
        q_pc_q    <= q_pc_d;
        tag_pc_q  <= tag_pc_d;
    end

    assign ImemReqValid_o = req_valid;
    assign ImemAddr_o     = rst_i ? 32'd0 : fpc_q;
    assign InstrValid_o   = head_valid;
    assign Instr_o        = head_valid ? q_instr_q[qrd_q] : 32'd0;
    assign InstrPC_o      = head_valid ? q_pc_q[qrd_q] : 32'd0;
    assign InstrPCPlus4_o = head_valid ? (q_pc_q[qrd_q] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a memory model with random latency and a
// transaction-level reference of requests, stale responses and the delivered stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Redirect_i;
  logic [31:0] RedirectPC_i;
  logic        ImemReqValid_o;
  logic        ImemReqReady_i;
  logic [31:0] ImemAddr_o;
  logic        ImemRespValid_i;
  logic [31:0] ImemRespData_i;
  logic        InstrValid_o;
  logic        InstrReady_i;
  logic [31:0] Instr_o;
  logic [31:0] InstrPC_o;
  logic [31:0] InstrPCPlus4_o;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .Redirect_i     (Redirect_i),
    .RedirectPC_i   (RedirectPC_i),
    .ImemReqValid_o (ImemReqValid_o),
    .ImemReqReady_i (ImemReqReady_i),
    .ImemAddr_o     (ImemAddr_o),
    .ImemRespValid_i(ImemRespValid_i),
    .ImemRespData_i (ImemRespData_i),
    .InstrValid_o   (InstrValid_o),
    .InstrReady_i   (InstrReady_i),
    .Instr_o        (Instr_o),
    .InstrPC_o      (InstrPC_o),
    .InstrPCPlus4_o (InstrPCPlus4_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // stimulus controls
  int          rdy_pct  = 100;
  int          dec_pct  = 100;
  int          redir_pct = 0;
  int          resp_pct = 100;
  int          max_lat  = 1;
  bit          force_redir = 1'b0;
  logic [31:0] force_tgt   = 32'd0;

  // reference model: outstanding memory requests and the decode-side queue
  logic [31:0] pend_pc[$];
  int          pend_due[$];
  bit          pend_stale[$];
  logic [31:0] iq_instr[$];
  logic [31:0] iq_pc[$];
  logic [31:0] exp_fpc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] pick_target();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0100;
      1: return 32'h0000_0203;
      2: return 32'h0000_0400;
      3: return 32'hFFFF_FFFC;
      4: return 32'hFFFF_FFF6;
      default: return $urandom() & 32'h0000_FFFF;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    pend_pc.delete();
    pend_due.delete();
    pend_stale.delete();
    iq_instr.delete();
    iq_pc.delete();
    exp_fpc = RESET_PC;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 32'(ImemReqValid_o), 32'd0);
    check_eq({tag, "_addr"}, ImemAddr_o, 32'd0);
    check_eq({tag, "_instr_valid"}, 32'(InstrValid_o), 32'd0);
    check_eq({tag, "_instr"}, Instr_o, 32'd0);
    check_eq({tag, "_pc"}, InstrPC_o, 32'd0);
    check_eq({tag, "_pc4"}, InstrPCPlus4_o, 32'd0);
  endtask

  task automatic check_outputs(output bit exp_rv);
    bit draining = 1'b0;
    foreach (pend_stale[i]) if (pend_stale[i]) draining = 1'b1;
    exp_rv = !draining && ((iq_pc.size() + pend_pc.size()) < DEPTH);
    check_eq("req_valid", 32'(ImemReqValid_o), 32'(exp_rv));
    check_eq("req_addr", ImemAddr_o, exp_fpc);
    check_eq("instr_valid", 32'(InstrValid_o), 32'(iq_pc.size() > 0));
    if (iq_pc.size() > 0) begin
      check_eq("instr", Instr_o, iq_instr[0]);
      check_eq("instr_pc", InstrPC_o, iq_pc[0]);
      check_eq("instr_pc4", InstrPCPlus4_o, iq_pc[0] + 32'd4);
    end
  endtask

  // driver: called at a falling edge, checks, drives one cycle, advances the model
  task automatic step();
    bit          rv, r, a, v, pop, st;
    logic [31:0] tgt, pc;
    #1;
    check_outputs(rv);
    ImemReqReady_i = ($urandom_range(0, 99) < rdy_pct);
    InstrReady_i   = ($urandom_range(0, 99) < dec_pct);
    r   = force_redir || ($urandom_range(0, 99) < redir_pct);
    tgt = force_redir ? force_tgt : pick_target();
    force_redir  = 1'b0;
    Redirect_i   = r;
    RedirectPC_i = r ? tgt : $urandom();
    v = (pend_pc.size() > 0) && (pend_due[0] <= cyc) && ($urandom_range(0, 99) < resp_pct);
    ImemRespValid_i = v;
    ImemRespData_i  = v ? mem_word(pend_pc[0]) : $urandom();
    a   = rv && ImemReqReady_i;
    pop = (iq_pc.size() > 0) && InstrReady_i;

    st = 1'b0;
    pc = 32'd0;
    if (v) begin
      pc = pend_pc.pop_front();
      st = pend_stale.pop_front();
      void'(pend_due.pop_front());
    end
    if (r) begin
      iq_instr.delete();
      iq_pc.delete();
      foreach (pend_stale[i]) pend_stale[i] = 1'b1;
    end else begin
      if (pop) begin
        void'(iq_instr.pop_front());
        void'(iq_pc.pop_front());
      end
      if (v && !st) begin
        iq_instr.push_back(mem_word(pc));
        iq_pc.push_back(pc);
      end
    end
    if (a) begin
      pend_pc.push_back(exp_fpc);
      pend_due.push_back(cyc + $urandom_range(1, max_lat));
      pend_stale.push_back(r);
    end
    if (r) exp_fpc = tgt & ~32'd3;
    else if (a) exp_fpc = exp_fpc + 32'd4;

    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect_now(input logic [31:0] tgt);
    force_redir = 1'b1;
    force_tgt   = tgt;
    step();
  endtask

  // asynchronous reset in the middle of a cycle; called at a falling edge
  task automatic do_reset();
    Redirect_i      = 1'b0;
    ImemRespValid_i = 1'b0;
    ImemReqReady_i  = 1'b0;
    InstrReady_i    = 1'b0;
    rst_i           = 1'b1;
    #1;
    check_zero_outputs("rst_async");
    @(posedge clk_i);
    @(negedge clk_i);
    check_zero_outputs("rst_hold");
    rst_i = 1'b0;
    model_clear();
  endtask

  initial begin
    rst_i           = 1'b1;
    Redirect_i      = 1'b0;
    RedirectPC_i    = 32'd0;
    ImemReqReady_i  = 1'b0;
    ImemRespValid_i = 1'b0;
    ImemRespData_i  = 32'd0;
    InstrReady_i    = 1'b0;
    model_clear();
    #3;
    check_zero_outputs("rst_init");
    @(posedge clk_i);
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // streaming from reset with a single-cycle memory
    run_n(12);

    // decode stall fills the queue, then releases
    dec_pct = 0;
    run_n(5);
    dec_pct = 100;
    run_n(8);

    // redirect with requests in flight
    max_lat = 4;
    run_n(3);
    redirect_now(32'h0000_0100);
    run_n(12);
    max_lat = 1;

    // redirect with nothing outstanding, unaligned target
    rdy_pct = 0;
    run_n(6);
    rdy_pct = 100;
    redirect_now(32'h0000_0203);
    run_n(6);

    // second redirect while still draining the first
    max_lat = 4;
    run_n(3);
    redirect_now(32'h0000_0100);
    redirect_now(32'h0000_0400);
    run_n(12);
    max_lat = 1;

    // PC wrap at the top of the address space
    rdy_pct = 0;
    run_n(4);
    rdy_pct = 100;
    redirect_now(32'hFFFF_FFFC);
    run_n(6);

    // reset with a non-empty queue
    dec_pct = 0;
    run_n(6);
    do_reset();
    dec_pct = 100;
    run_n(8);

    // randomized traffic with periodic setting changes and resets
    for (int blk = 0; blk < 16; blk++) begin
      rdy_pct   = $urandom_range(30, 100);
      dec_pct   = $urandom_range(20, 100);
      redir_pct = $urandom_range(0, 8);
      resp_pct  = $urandom_range(40, 100);
      max_lat   = $urandom_range(1, 4);
      run_n(100);
      if (blk % 5 == 4) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
